// File: rtl/video_timing_pkg.sv
// video_timing_pkg
//   Shared types and helpers for the video timing controller.
//   - vtc_timing_t : one complete H/V timing set (eight VTC_CW-bit fields)
//   - vtc_state_t  : sequencer state {IDLE, RUN, DRAIN}
//   - DEF_*        : power-up timing (1280x720 style)
//   - span_total / span_fits / timing_ok : validation of an offered timing set
package video_timing_pkg;

  localparam int VTC_CW = 12;

  typedef logic [VTC_CW-1:0] vtc_field_t;

  typedef struct packed {
    vtc_field_t hr;
    vtc_field_t hfp;
    vtc_field_t hs;
    vtc_field_t hbp;
    vtc_field_t vr;
    vtc_field_t vfp;
    vtc_field_t vs;
    vtc_field_t vbp;
  } vtc_timing_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } vtc_state_t;

  localparam int DEF_HR  = 1280;
  localparam int DEF_HFP = 180;
  localparam int DEF_HS  = 9;
  localparam int DEF_HBP = 180;
  localparam int DEF_VR  = 720;
  localparam int DEF_VFP = 10;
  localparam int DEF_VS  = 10;
  localparam int DEF_VBP = 10;

  // Sum of four spans, two bits wider than a field so overflow is visible.
  function automatic logic [VTC_CW+1:0] span_total(input vtc_field_t a, input vtc_field_t b,
                                                   input vtc_field_t c, input vtc_field_t d);
    return {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
  endfunction

  // A total is usable only if it still fits in a field-wide counter.
  function automatic logic span_fits(input logic [VTC_CW+1:0] tot);
    return tot[VTC_CW+1:VTC_CW] == 2'b00;
  endfunction

  function automatic logic timing_ok(input vtc_timing_t t);
    logic nonzero;
    nonzero = (t.hr != '0) && (t.hfp != '0) && (t.hs != '0) && (t.hbp != '0) &&
              (t.vr != '0) && (t.vfp != '0) && (t.vs != '0) && (t.vbp != '0);
    return nonzero && span_fits(span_total(t.hr, t.hfp, t.hs, t.hbp))
                   && span_fits(span_total(t.vr, t.vfp, t.vs, t.vbp));
  endfunction

endpackage

// File: rtl/vtc_span_counter.sv
// vtc_span_counter
//   One wrapping position counter (line or frame axis) with region decode.
//   Span order: active, front porch, sync, back porch; total = sum of the four.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     clr_i               hold the counter at 0
//     adv_i               advance by one (wraps from total-1 to 0)
//     act_i/fp_i/sync_i/bp_i  span lengths (validated upstream, nonzero, sum fits)
//     cnt_o               current position
//     last_o              position == total-1
//     act_o               position inside the active span
//     sync_o              position inside the sync span
//     cnt_d_o             next position (only with VTC_PIXEL_REQ_EN defined)
module vtc_span_counter
  import video_timing_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              adv_i,
  input  logic [VTC_CW-1:0] act_i,
  input  logic [VTC_CW-1:0] fp_i,
  input  logic [VTC_CW-1:0] sync_i,
  input  logic [VTC_CW-1:0] bp_i,
  output logic [VTC_CW-1:0] cnt_o,
  output logic              last_o,
  output logic              act_o,
  output logic              sync_o
`ifdef VTC_PIXEL_REQ_EN
  ,
  output logic [VTC_CW-1:0] cnt_d_o
`endif
);

  logic [VTC_CW-1:0] cnt_q, cnt_d;
  logic [VTC_CW-1:0] sync_lo, sync_hi, total;

  // Spans were validated to fit in VTC_CW bits, so no wider arithmetic is needed.
  assign sync_lo = act_i + fp_i;
  assign sync_hi = sync_lo + sync_i;
  assign total   = sync_hi + bp_i;

  assign last_o = (cnt_q == total - 1'b1);
  assign act_o  = (cnt_q < act_i);
  assign sync_o = (cnt_q >= sync_lo) && (cnt_q < sync_hi);
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (adv_i) begin
      cnt_d = last_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

`ifdef VTC_PIXEL_REQ_EN
  assign cnt_d_o = cnt_d;
`endif

endmodule

// File: rtl/video_timing_ctrl.sv
// video_timing_ctrl
//   Run-time programmable video timing controller. Owns H/V counters, sequences
//   frame start/stop and emits de/hs/vs plus active pixel coordinates. New timing
//   sets are held in a one-deep pending slot and applied only at a frame boundary
//   (or immediately when idle), so a frame is never torn.
//   Optional feature macro: VTC_PIXEL_REQ_EN adds pix_req, high one clock before
//   every de-high cycle.
//   Ports:
//     clk, rst_n               pixel clock, asynchronous active-low reset
//     en                       1 = run, 0 = stop at end of current frame
//     cfg_valid / cfg_ready    timing-set handshake (cfg_ready = pending slot empty)
//     cfg_hr..cfg_hbp          horizontal spans; cfg_vr..cfg_vbp vertical spans
//     cfg_err                  one-clock pulse when an offered set is rejected
//     busy                     sequencer not idle
//     de, hs, vs               data enable and syncs (sync polarity by HS_POL/VS_POL)
//     pix_x, pix_y             active coordinates, 0 outside the active area
//     frame_start, line_start  pulses on first pixel of frame / first cycle of line
//   CW must equal video_timing_pkg::VTC_CW.
module video_timing_ctrl
  import video_timing_pkg::*;
#(
  parameter int CW     = VTC_CW,
  parameter int HR     = DEF_HR,
  parameter int HFP    = DEF_HFP,
  parameter int HS     = DEF_HS,
  parameter int HBP    = DEF_HBP,
  parameter int VR     = DEF_VR,
  parameter int VFP    = DEF_VFP,
  parameter int VS     = DEF_VS,
  parameter int VBP    = DEF_VBP,
  parameter bit HS_POL = 1'b1,
  parameter bit VS_POL = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [CW-1:0] cfg_hr,
  input  logic [CW-1:0] cfg_hfp,
  input  logic [CW-1:0] cfg_hs,
  input  logic [CW-1:0] cfg_hbp,
  input  logic [CW-1:0] cfg_vr,
  input  logic [CW-1:0] cfg_vfp,
  input  logic [CW-1:0] cfg_vs,
  input  logic [CW-1:0] cfg_vbp,
  output logic          cfg_err,
  output logic          busy,
  output logic          de,
  output logic          hs,
  output logic          vs,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          frame_start,
  output logic          line_start
`ifdef VTC_PIXEL_REQ_EN
  ,
  output logic          pix_req
`endif
);

  localparam vtc_timing_t DEF_TIMING = '{
    hr:  vtc_field_t'(HR), hfp: vtc_field_t'(HFP), hs: vtc_field_t'(HS), hbp: vtc_field_t'(HBP),
    vr:  vtc_field_t'(VR), vfp: vtc_field_t'(VFP), vs: vtc_field_t'(VS), vbp: vtc_field_t'(VBP)
  };

  vtc_state_t  state_q, state_d;
  vtc_timing_t active_q, active_d;
  vtc_timing_t pend_q, pend_d;
  logic        pend_vld_q, pend_vld_d;
  vtc_timing_t offer;

  logic        running, frame_last, accept, apply;
  logic [VTC_CW-1:0] h_cnt, v_cnt;
  logic        h_last, h_act, h_sync;
  logic        v_last, v_act, v_sync;

  logic        de_q, de_d, hs_q, hs_d, vs_q, vs_d;
  logic        fs_q, fs_d, ls_q, ls_d, busy_q, busy_d, err_q, err_d;
  logic [CW-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;

  assign running    = (state_q != IDLE);
  assign frame_last = running && h_last && v_last;

  always_comb begin
    offer = '{hr: cfg_hr, hfp: cfg_hfp, hs: cfg_hs, hbp: cfg_hbp,
              vr: cfg_vr, vfp: cfg_vfp, vs: cfg_vs, vbp: cfg_vbp};
  end

  // ---------------- counters ----------------
`ifdef VTC_PIXEL_REQ_EN
  logic [VTC_CW-1:0] h_cnt_d, v_cnt_d;
`endif

  vtc_span_counter u_h_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (!running),
    .adv_i  (running),
    .act_i  (active_q.hr),
    .fp_i   (active_q.hfp),
    .sync_i (active_q.hs),
    .bp_i   (active_q.hbp),
    .cnt_o  (h_cnt),
    .last_o (h_last),
    .act_o  (h_act),
    .sync_o (h_sync)
`ifdef VTC_PIXEL_REQ_EN
    ,
    .cnt_d_o(h_cnt_d)
`endif
  );

  // Vertical axis steps once per completed line.
  vtc_span_counter u_v_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (!running),
    .adv_i  (running && h_last),
    .act_i  (active_q.vr),
    .fp_i   (active_q.vfp),
    .sync_i (active_q.vs),
    .bp_i   (active_q.vbp),
    .cnt_o  (v_cnt),
    .last_o (v_last),
    .act_o  (v_act),
    .sync_o (v_sync)
`ifdef VTC_PIXEL_REQ_EN
    ,
    .cnt_d_o(v_cnt_d)
`endif
  );

  // ---------------- sequencer ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (en) state_d = RUN;
      RUN: begin
        if (frame_last)  state_d = en ? RUN : IDLE;
        else if (!en)    state_d = DRAIN;
      end
      DRAIN: begin
        if (frame_last)  state_d = en ? RUN : IDLE;
        else if (en)     state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- configuration shadowing ----------------
  // accept and apply are mutually exclusive: accept needs an empty slot,
  // apply a full one. A set accepted on a boundary cycle therefore waits
  // for the following boundary.
  assign accept    = cfg_valid && !pend_vld_q;
  assign apply     = pend_vld_q && (frame_last || !running);
  assign cfg_ready = !pend_vld_q;

  always_comb begin
    active_d   = active_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    err_d      = 1'b0;
    if (apply) begin
      active_d   = pend_q;
      pend_vld_d = 1'b0;
    end
    if (accept) begin
      if (timing_ok(offer)) begin
        pend_d     = offer;
        pend_vld_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // ---------------- output decode (registered one clock behind counters) ----------------
  always_comb begin
    de_d    = running && h_act && v_act;
    hs_d    = (running && h_sync) ? HS_POL : !HS_POL;
    vs_d    = (running && v_sync) ? VS_POL : !VS_POL;
    pix_x_d = de_d ? CW'(h_cnt) : '0;
    pix_y_d = de_d ? CW'(v_cnt) : '0;
    ls_d    = running && (h_cnt == '0);
    fs_d    = ls_d && (v_cnt == '0);
    busy_d  = running;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      active_q   <= DEF_TIMING;
      pend_q     <= DEF_TIMING;
      pend_vld_q <= 1'b0;
      err_q      <= 1'b0;
      de_q       <= 1'b0;
      hs_q       <= !HS_POL;
      vs_q       <= !VS_POL;
      pix_x_q    <= '0;
      pix_y_q    <= '0;
      fs_q       <= 1'b0;
      ls_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      active_q   <= active_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      err_q      <= err_d;
      de_q       <= de_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      pix_x_q    <= pix_x_d;
      pix_y_q    <= pix_y_d;
      fs_q       <= fs_d;
      ls_q       <= ls_d;
      busy_q     <= busy_d;
    end
  end

  assign cfg_err     = err_q;
  assign busy        = busy_q;
  assign de          = de_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign frame_start = fs_q;
  assign line_start  = ls_q;

`ifdef VTC_PIXEL_REQ_EN
  // de is decoded from the current counters, so pix_req decodes the counters'
  // next values (with the timing that will be active then) to lead by one clock.
  logic pix_req_q, pix_req_d;

  assign pix_req_d = (state_d != IDLE) && (h_cnt_d < active_d.hr) && (v_cnt_d < active_d.vr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_req_q <= 1'b0;
    end else begin
      pix_req_q <= pix_req_d;
    end
  end

  assign pix_req = pix_req_q;
`endif

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Testbench for video_timing_ctrl using the small timing set
// (H: 4/1/2/1 -> 8 clk per line, V: 3/1/1/1 -> 6 lines per frame).
// The reference model tracks a frame position p and derives h = p % Htot,
// v = p / Htot; expected outputs are those of the position one clock earlier.
module tb_video_timing_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [11:0] cfg_hr, cfg_hfp, cfg_hs, cfg_hbp, cfg_vr, cfg_vfp, cfg_vs, cfg_vbp;
  logic        cfg_err, busy, de, hs, vs, frame_start, line_start;
  logic [11:0] pix_x, pix_y;
`ifdef VTC_PIXEL_REQ_EN
  logic        pix_req;
`endif

  video_timing_ctrl #(
    .CW(12), .HR(4), .HFP(1), .HS(2), .HBP(1), .VR(3), .VFP(1), .VS(1), .VBP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_hr(cfg_hr), .cfg_hfp(cfg_hfp), .cfg_hs(cfg_hs), .cfg_hbp(cfg_hbp),
    .cfg_vr(cfg_vr), .cfg_vfp(cfg_vfp), .cfg_vs(cfg_vs), .cfg_vbp(cfg_vbp),
    .cfg_err(cfg_err), .busy(busy), .de(de), .hs(hs), .vs(vs),
    .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start), .line_start(line_start)
`ifdef VTC_PIXEL_REQ_EN
    , .pix_req(pix_req)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // model state
  bit m_run, m_pv;
  int m_p;
  int m_hr, m_hfp, m_hs, m_hbp, m_vr, m_vfp, m_vs, m_vbp;
  int p_hr, p_hfp, p_hs, p_hbp, p_vr, p_vfp, p_vs, p_vbp;
  int cnt_de, cnt_hs, cnt_vs, cnt_fs, cnt_ls;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic bit set_ok(input int a, input int b, input int c, input int d,
                                input int e, input int f, input int g, input int h);
    return (a != 0) && (b != 0) && (c != 0) && (d != 0) && (e != 0) && (f != 0) &&
           (g != 0) && (h != 0) && (a + b + c + d <= 4095) && (e + f + g + h <= 4095);
  endfunction

  task automatic model_reset();
    m_run = 0; m_pv = 0; m_p = 0;
    m_hr = 4; m_hfp = 1; m_hs = 2; m_hbp = 1;
    m_vr = 3; m_vfp = 1; m_vs = 1; m_vbp = 1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_de"}, de, 0);
    chk({tag, "_hs"}, hs, 0);
    chk({tag, "_vs"}, vs, 0);
    chk({tag, "_x"}, pix_x, 0);
    chk({tag, "_y"}, pix_y, 0);
    chk({tag, "_fs"}, frame_start, 0);
    chk({tag, "_ls"}, line_start, 0);
    chk({tag, "_err"}, cfg_err, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ready"}, cfg_ready, 1);
`ifdef VTC_PIXEL_REQ_EN
    chk({tag, "_req"}, pix_req, 0);
`endif
  endtask

  // One clock: derive expectations, advance the model, clock, compare.
  task automatic tick();
    int htot, vtot, h, v;
    int e_de, e_hs, e_vs, e_x, e_y, e_ls, e_fs, e_busy, e_err, e_ready, e_req;
    bit acc, okv, last, apply;
    htot = m_hr + m_hfp + m_hs + m_hbp;
    vtot = m_vr + m_vfp + m_vs + m_vbp;
    h = m_p % htot;
    v = m_p / htot;
    e_de   = int'(m_run && h < m_hr && v < m_vr);
    e_hs   = int'(m_run && h >= m_hr + m_hfp && h < m_hr + m_hfp + m_hs);
    e_vs   = int'(m_run && v >= m_vr + m_vfp && v < m_vr + m_vfp + m_vs);
    e_x    = (e_de != 0) ? h : 0;
    e_y    = (e_de != 0) ? v : 0;
    e_ls   = int'(m_run && h == 0);
    e_fs   = int'(m_run && m_p == 0);
    e_busy = int'(m_run);
    acc    = cfg_valid && !m_pv;
    okv    = set_ok(cfg_hr, cfg_hfp, cfg_hs, cfg_hbp, cfg_vr, cfg_vfp, cfg_vs, cfg_vbp);
    e_err  = int'(acc && !okv);
    last   = m_run && (m_p == htot * vtot - 1);
    apply  = m_pv && (last || !m_run);
    if (!m_run || last) begin
      m_run = en;
      m_p = 0;
    end else begin
      m_p++;
    end
    if (apply) begin
      m_hr = p_hr; m_hfp = p_hfp; m_hs = p_hs; m_hbp = p_hbp;
      m_vr = p_vr; m_vfp = p_vfp; m_vs = p_vs; m_vbp = p_vbp;
      m_pv = 0;
    end
    if (acc && okv) begin
      p_hr = cfg_hr; p_hfp = cfg_hfp; p_hs = cfg_hs; p_hbp = cfg_hbp;
      p_vr = cfg_vr; p_vfp = cfg_vfp; p_vs = cfg_vs; p_vbp = cfg_vbp;
      m_pv = 1;
    end
    e_ready = int'(!m_pv);
    htot = m_hr + m_hfp + m_hs + m_hbp;
    e_req = int'(m_run && (m_p % htot) < m_hr && (m_p / htot) < m_vr);
    @(posedge clk);
    #1;
    chk("de", de, e_de);
    chk("hs", hs, e_hs);
    chk("vs", vs, e_vs);
    chk("pix_x", pix_x, e_x);
    chk("pix_y", pix_y, e_y);
    chk("line_start", line_start, e_ls);
    chk("frame_start", frame_start, e_fs);
    chk("busy", busy, e_busy);
    chk("cfg_err", cfg_err, e_err);
    chk("cfg_ready", cfg_ready, e_ready);
`ifdef VTC_PIXEL_REQ_EN
    chk("pix_req", pix_req, e_req);
`else
    if (e_req < 0) chk("pix_req_model", 0, 1);
`endif
    cnt_de += int'(de);
    cnt_hs += int'(hs);
    cnt_vs += int'(vs);
    cnt_fs += int'(frame_start);
    cnt_ls += int'(line_start);
  endtask

  task automatic clear_counts();
    cnt_de = 0; cnt_hs = 0; cnt_vs = 0; cnt_fs = 0; cnt_ls = 0;
  endtask

  // Advance until the model (== DUT counter state) sits at frame position target.
  task automatic run_to(input int target);
    int n;
    n = 0;
    while (!(m_run && m_p == target) && n < 2000) begin
      tick();
      n++;
    end
    chk("run_to_bound", n < 2000, 1);
  endtask

  task automatic offer(input int a, input int b, input int c, input int d,
                       input int e, input int f, input int g, input int h);
    cfg_valid = 1'b1;
    cfg_hr = 12'(a); cfg_hfp = 12'(b); cfg_hs = 12'(c); cfg_hbp = 12'(d);
    cfg_vr = 12'(e); cfg_vfp = 12'(f); cfg_vs = 12'(g); cfg_vbp = 12'(h);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_slot_empty();
    int n;
    n = 0;
    while (m_pv && n < 3000) begin
      tick();
      n++;
    end
    chk("slot_bound", n < 3000, 1);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0;
    cfg_hr = 12'd4; cfg_hfp = 12'd1; cfg_hs = 12'd2; cfg_hbp = 12'd1;
    cfg_vr = 12'd3; cfg_vfp = 12'd1; cfg_vs = 12'd1; cfg_vbp = 12'd1;
    model_reset();
    clear_counts();
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) tick();

    // first frame: 48 clk, de 12, hs 2 per line, vs 8 clk, one frame_start
    en = 1'b1;
    tick();
    clear_counts();
    repeat (48) tick();
    chk("frame_de_count", cnt_de, 12);
    chk("frame_hs_count", cnt_hs, 12);
    chk("frame_vs_count", cnt_vs, 8);
    chk("frame_fs_count", cnt_fs, 1);
    chk("frame_ls_count", cnt_ls, 6);
    repeat (48) tick();

    // stop requested at v=1: frame completes, then idle
    run_to(8);
    en = 1'b0;
    repeat (45) tick();
    chk("stopped_busy", busy, 0);

    // DRAIN re-entered by en=1: seamless continuation
    en = 1'b1;
    run_to(20);
    en = 1'b0;
    repeat (10) tick();
    en = 1'b1;
    repeat (60) tick();

    // HR=6 offered mid-frame, applied at the boundary
    run_to(10);
    offer(6, 1, 2, 1, 3, 1, 1, 1);
    chk("pending_ready", cfg_ready, 0);
    run_to(0);
    clear_counts();
    repeat (60) tick();
    chk("hr6_de_count", cnt_de, 18);
    chk("hr6_ls_count", cnt_ls, 6);

    // rejected sets
    offer(6, 1, 0, 1, 3, 1, 1, 1);
    chk("zero_err", cfg_err, 1);
    chk("zero_ready", cfg_ready, 1);
    repeat (3) tick();
    offer(4000, 100, 1, 1, 3, 1, 1, 1);
    chk("ovf_err", cfg_err, 1);
    chk("ovf_ready", cfg_ready, 1);
    repeat (70) tick();

    // randomized traffic
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 39) == 0) en = ~en;
      if ($urandom_range(0, 24) == 0) begin
        cfg_valid = 1'b1;
        cfg_hr  = 12'($urandom_range(1, 5)); cfg_hfp = 12'($urandom_range(1, 5));
        cfg_hs  = 12'($urandom_range(1, 5)); cfg_hbp = 12'($urandom_range(1, 5));
        cfg_vr  = 12'($urandom_range(1, 5)); cfg_vfp = 12'($urandom_range(1, 5));
        cfg_vs  = 12'($urandom_range(1, 5)); cfg_vbp = 12'($urandom_range(1, 5));
        case ($urandom_range(0, 7))
          0: cfg_hs = 12'd0;
          1: cfg_vbp = 12'd0;
          2: begin cfg_vr = 12'd4000; cfg_vfp = 12'd200; end
          default: ;
        endcase
      end else begin
        cfg_valid = 1'b0;
      end
      tick();
    end
    cfg_valid = 1'b0;

    // back to the small timing, then asynchronous reset at v=2,h=3 with a set pending
    en = 1'b1;
    wait_slot_empty();
    offer(4, 1, 2, 1, 3, 1, 1, 1);
    wait_slot_empty();
    run_to(0);
    offer(5, 2, 1, 1, 2, 1, 1, 1);
    run_to(19);
    #2;
    rst_n = 1'b0;
    en = 1'b0;
    #1;
    chk_reset("async_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    en = 1'b1;
    clear_counts();
    repeat (49) tick();
    chk("post_reset_de_count", cnt_de, 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
